// File: rtl/timer_ctrl.sv
// Sequencer for a 16-bit down-counting timer: loads, runs, pauses, reloads in
// periodic mode and reports expiries. Outputs decode from state plus tmr_dout/pause/stop.
module timer_ctrl #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             sclr,
   input  logic             start,
   input  logic             stop,
   input  logic             pause,
   input  logic [WIDTH-1:0] period,
   input  logic             periodic,
   input  logic [CNT_W-1:0] reps,
   input  logic [WIDTH-1:0] tmr_dout,
   output logic [WIDTH-1:0] tmr_din,
   output logic             tmr_ld,
   output logic             tmr_cnt_en,
   output logic             tmr_aclr,
   output logic             busy,
   output logic             expire,
   output logic             done,
   output logic             err,
   output logic [CNT_W-1:0] expire_cnt,
   output logic [2:0]       dbg_state
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_RUN   = 3'd2;
   localparam logic [2:0] S_PAUSE = 3'd3;
   localparam logic [2:0] S_CLR   = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   logic [2:0]       r_state;
   logic [2:0]       w_next;
   logic [WIDTH-1:0] r_period;
   logic             r_periodic;
   logic [CNT_W-1:0] r_reps;
   logic [CNT_W-1:0] r_expire_cnt;
   logic             r_err;
   logic             w_tc;
   logic             w_accept;
   logic             w_reject;
   logic             w_expire;
   logic             w_more;
   logic [CNT_W:0]   w_cnt_inc;

   assign w_tc      = (tmr_dout == '0);
   assign w_accept  = (r_state == S_IDLE) & start & (period != '0);
   assign w_reject  = (r_state == S_IDLE) & start & (period == '0);
   assign w_expire  = (r_state == S_RUN) & w_tc & ~pause & ~stop & ~sclr;
   // One extra bit so the reps comparison is exact even when the counter is saturated.
   assign w_cnt_inc = {1'b0, r_expire_cnt} + {{CNT_W{1'b0}}, 1'b1};
   assign w_more    = r_periodic & ((r_reps == '0) | (w_cnt_inc < {1'b0, r_reps}));

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next = S_LOAD;
         S_LOAD:  w_next = stop ? S_CLR : S_RUN;
         S_RUN: begin
            if (stop)       w_next = S_CLR;
            else if (pause) w_next = S_PAUSE;
            else if (w_tc)  w_next = w_more ? S_LOAD : S_DONE;
         end
         S_PAUSE: begin
            if (stop)        w_next = S_CLR;
            else if (!pause) w_next = S_RUN;
         end
         S_DONE:  w_next = stop ? S_CLR : S_IDLE;
         S_CLR:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (sclr) begin
         r_state      <= S_IDLE;
         r_period     <= '0;
         r_periodic   <= 1'b0;
         r_reps       <= '0;
         r_expire_cnt <= '0;
         r_err        <= 1'b0;
      end else begin
         r_state <= w_next;
         r_err   <= w_reject;
         if (w_accept) begin
            r_period     <= period;
            r_periodic   <= periodic;
            r_reps       <= reps;
            r_expire_cnt <= '0;
         end else if (w_expire && (r_expire_cnt != '1)) begin
            r_expire_cnt <= w_cnt_inc[CNT_W-1:0];
         end
      end
   end

   assign tmr_din    = r_period;
   assign tmr_ld     = (r_state == S_LOAD);
   assign tmr_cnt_en = (r_state == S_RUN) & ~w_tc & ~pause & ~stop;
   assign tmr_aclr   = sclr | (r_state == S_CLR);
   assign busy       = (r_state != S_IDLE);
   assign expire     = w_expire;
   assign done       = (r_state == S_DONE) & ~stop & ~sclr;
   assign err        = r_err;
   assign expire_cnt = r_expire_cnt;
   assign dbg_state  = r_state;

endmodule
